// File: rtl/switch_debounce_sync_if.sv
// Switch conditioning bundle: raw switch levels in, debounced levels and edge pulses out.
// The debouncer itself connects through the slave modport.
interface switch_debounce_sync_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_stable;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             any_change;

   modport master (
      output sw_raw,
      input  sw_stable, sw_rise, sw_fall, any_change
   );

   modport slave (
      input  sw_raw,
      output sw_stable, sw_rise, sw_fall, any_change
   );
endinterface

// File: rtl/switch_debounce_sync.sv
// Synchronises, debounces and edge-detects raw switch inputs ahead of a PIO input port.
// Each bit must hold a new level for DEBOUNCE_TICKS prescaler ticks before it is accepted.
module switch_debounce_sync #(
   parameter int WIDTH          = 1,
   parameter int SYNC_STAGES    = 2,
   parameter int TICK_DIV       = 1,
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   switch_debounce_sync_if.slave sw
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic             tick;
   logic [CNT_W-1:0] cnt        [WIDTH];
   logic [CNT_W-1:0] cnt_nxt    [WIDTH];
   logic [WIDTH-1:0] stable_nxt;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
      end else begin
         sync_chain[0] <= sw.sw_raw;
         for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
      end
   end

   assign sync = sync_chain[SYNC_STAGES-1];

   // Free-running prescaler; a divide of one degenerates to a permanent tick.
   generate
      if (TICK_DIV == 1) begin : g_no_div
         assign tick = 1'b1;
      end else begin : g_div
         localparam int               DIV_W    = $clog2(TICK_DIV);
         localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
         logic [DIV_W-1:0] div_cnt;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                div_cnt <= '0;
            else if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                          div_cnt <= div_cnt + 1'b1;
         end

         assign tick = (div_cnt == DIV_LAST);
      end
   endgenerate

   always_comb begin
      stable_nxt = sw.sw_stable;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (sync[i] == sw.sw_stable[i]) begin
            cnt_nxt[i] = '0;
         end else if (tick) begin
            if (cnt[i] == CNT_LAST) begin
               stable_nxt[i] = sync[i];
               cnt_nxt[i]    = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end
      end
   end

   assign rise_nxt = stable_nxt & ~sw.sw_stable;
   assign fall_nxt = ~stable_nxt & sw.sw_stable;

   // Pulses are registered on the same edge as the level so they line up with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         sw.sw_stable  <= '0;
         sw.sw_rise    <= '0;
         sw.sw_fall    <= '0;
         sw.any_change <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
         sw.sw_stable  <= stable_nxt;
         sw.sw_rise    <= rise_nxt;
         sw.sw_fall    <= fall_nxt;
         sw.any_change <= |(rise_nxt | fall_nxt);
      end
   end
endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: table vectors, hand-written corner sequences and a random run
// against a sample-window reference model, plus a TICK_DIV=4 instance for prescaled latency.
module tb_switch_debounce_sync;
   localparam int W    = 4;
   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int HIST = SYNC + DEB;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic reset2_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   switch_debounce_sync_if #(.WIDTH(W)) bus  ();
   switch_debounce_sync_if #(.WIDTH(W)) bus2 ();

   switch_debounce_sync #(.WIDTH(W), .SYNC_STAGES(SYNC), .TICK_DIV(1), .DEBOUNCE_TICKS(DEB)) dut (
      .clk(clk), .reset_n(reset_n), .sw(bus));

   switch_debounce_sync #(.WIDTH(W), .SYNC_STAGES(SYNC), .TICK_DIV(4), .DEBOUNCE_TICKS(DEB)) dut2 (
      .clk(clk), .reset_n(reset2_n), .sw(bus2));

   // Reference model: raw samples per edge; a bit flips when the DEB samples taken
   // SYNC..SYNC+DEB-1 edges ago all disagree with the current stable level.
   logic [W-1:0] hist [$];
   logic [W-1:0] m_stable, m_rise, m_fall;
   logic         m_any;

   typedef struct {
      logic [W-1:0] raw;
      int           n;
      logic [W-1:0] stable;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         any;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected within [%0d,%0d]", name, act, lo, hi);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < HIST; k++) hist.push_back('0);
      m_stable = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
   endtask

   task automatic reset1(input logic [W-1:0] raw);
      bus.sw_raw = raw;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_stable", bus.sw_stable, 0);
      check("rst_rise",   bus.sw_rise,   0);
      check("rst_fall",   bus.sw_fall,   0);
      check("rst_any",    bus.any_change, 0);
      reset_n = 1'b1;
   endtask

   // One clock of dut: drive raw, advance the model on the edge, compare at the falling edge.
   task automatic tick_cycle(input logic [W-1:0] raw);
      logic [W-1:0] nxt;
      logic         all_diff;
      bus.sw_raw = raw;
      @(posedge clk);
      hist.push_back(raw);
      void'(hist.pop_front());
      nxt = m_stable;
      for (int i = 0; i < W; i++) begin
         all_diff = 1'b1;
         for (int k = 0; k < DEB; k++)
            if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
         if (all_diff) nxt[i] = ~m_stable[i];
      end
      m_rise   = nxt & ~m_stable;
      m_fall   = ~nxt & m_stable;
      m_any    = |(m_rise | m_fall);
      m_stable = nxt;
      @(negedge clk);
      check("model_stable", bus.sw_stable,  m_stable);
      check("model_rise",   bus.sw_rise,    m_rise);
      check("model_fall",   bus.sw_fall,    m_fall);
      check("model_any",    bus.any_change, m_any);
   endtask

   task automatic measure2(output int lat, output int rises);
      lat   = 999;
      rises = 0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus2.sw_rise[0]) rises++;
         if (bus2.sw_stable[0]) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      logic [W-1:0] raw;
      int           cnt_b1, cnt_rise, rise_at, lat, rises;

      bus.sw_raw  = '0;
      bus2.sw_raw = '0;

      tbl[0] = '{4'hF,  9, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[1] = '{4'hF,  1, 4'hF, 4'hF, 4'h0, 1'b1};
      tbl[2] = '{4'hF,  1, 4'hF, 4'h0, 4'h0, 1'b0};
      tbl[3] = '{4'h0,  7, 4'hF, 4'h0, 4'h0, 1'b0};
      tbl[4] = '{4'hF, 12, 4'hF, 4'h0, 4'h0, 1'b0};
      tbl[5] = '{4'h1, 10, 4'h1, 4'h0, 4'hE, 1'b1};
      tbl[6] = '{4'h8, 10, 4'h8, 4'h8, 4'h1, 1'b1};
      tbl[7] = '{4'h8,  1, 4'h8, 4'h0, 4'h0, 1'b0};

      @(negedge clk);
      reset1(4'hF);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < tbl[r].n; c++) tick_cycle(tbl[r].raw);
         check($sformatf("vec%0d_stable", r), bus.sw_stable,  tbl[r].stable);
         check($sformatf("vec%0d_rise",   r), bus.sw_rise,    tbl[r].rise);
         check($sformatf("vec%0d_fall",   r), bus.sw_fall,    tbl[r].fall);
         check($sformatf("vec%0d_any",    r), bus.any_change, tbl[r].any);
      end

      // Seven-cycle glitch on bit 1 must vanish without trace.
      cnt_b1 = 0;
      for (int c = 0; c < 22; c++) begin
         tick_cycle((c < 7) ? 4'hA : 4'h8);
         if (bus.sw_stable[1] || bus.sw_rise[1] || bus.sw_fall[1] || bus.any_change) cnt_b1++;
      end
      check("glitch_activity", cnt_b1, 0);

      // Bit 2 bounces every 3 cycles for 30 cycles, then settles high at cycle 31.
      cnt_rise = 0;
      rise_at  = 0;
      for (int c = 1; c <= 60; c++) begin
         raw = 4'h8;
         raw[2] = (c > 30) ? 1'b1 : (((c - 1) / 3) % 2 == 0);
         tick_cycle(raw);
         if (bus.sw_rise[2]) begin
            cnt_rise++;
            rise_at = c;
         end
      end
      check("bounce_rise_count", cnt_rise, 1);
      check("bounce_rise_cycle", rise_at, 40);

      // Randomised run with long enough runs that some changes are accepted.
      raw = bus.sw_raw;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
         tick_cycle(raw);
      end

      // Prescaled instance: latency window, then a reset in the middle of a count.
      @(negedge clk);
      reset2_n = 1'b1;
      repeat (5) @(negedge clk);
      check("div_idle_stable", bus2.sw_stable, 0);
      bus2.sw_raw = 4'h1;
      measure2(lat, rises);
      check_range("div_latency", lat, 31, 34);
      check("div_rise_pulse", bus2.sw_rise, 4'h1);
      check("div_any_pulse", bus2.any_change, 1);
      bus2.sw_raw = 4'h0;
      repeat (40) @(negedge clk);
      check("div_back_low", bus2.sw_stable, 0);
      bus2.sw_raw = 4'h1;
      repeat (20) @(negedge clk);
      check("div_mid_stable", bus2.sw_stable, 0);
      reset2_n = 1'b0;
      #1;
      check("div_rst_stable", bus2.sw_stable, 0);
      check("div_rst_rise",   bus2.sw_rise,   0);
      check("div_rst_any",    bus2.any_change, 0);
      @(negedge clk);
      reset2_n = 1'b1;
      measure2(lat, rises);
      check_range("div_relatency", lat, 31, 34);
      check("div_rerise_count", rises, 1);
      @(negedge clk);
      check("div_rise_cleared", bus2.sw_rise, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
